fixed_point_divide: RTL and testbench
=====================================

# fixed_point_divide

Sequential Q8.8 sign-magnitude divider: the inverse of the team's combinational `fixed_point_math` multiplier.
- Computes `dividend / divisor` on the same 16-bit format using a restoring shift-subtract loop, one quotient bit per clock.
- Sits beside the multiplier in the FFT arithmetic datapath and serves normalisation and scaling paths that can tolerate multi-cycle latency.
- Uses a start/done handshake.

## Interface
Parameters:
- `WIDTH`, 16: total word width; bit `WIDTH-1` is sign, the rest is magnitude.
- `FRAC`, 8: fraction bits; 1.0 = 0x0100, 0.5 = 0x0080.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  16  numerator, sign-magnitude Q8.8; captured on accepted `start`.
- `divisor`  in  16  denominator, sign-magnitude Q8.8; captured on accepted `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  16  sign-magnitude Q8.8 result; held until the next accepted `start`.
- `overflow`  out  1  result saturated; held with `quotient`.
- `div_by_zero`  out  1  divisor magnitude was zero; held with `quotient`.

## Operation
- **States:**
  - IDLE → CALC on `start` with nonzero divisor magnitude.
  - IDLE → DONE on `start` with zero divisor magnitude.
  - CALC → DONE after `WIDTH-1+FRAC` (23) iterations.
  - DONE → IDLE unconditionally.
- **Capture:** on accept, latch the operand magnitudes, `sign = dividend[15] ^ divisor[15]`, and clear `overflow`/`div_by_zero`.
- **Numerator:** `|dividend| << FRAC`, 23 bits.
- **Iteration:** shift the remainder left by one and bring in the next numerator MSB. If `remainder >= |divisor|`, subtract and set the quotient bit to 1; otherwise set it to 0.
- **Widths:** remainder is 16 bits (magnitude + 1 guard bit); raw quotient is 23 bits.
- **Rounding:** truncation toward zero.
- **Overflow:** if raw quotient bits [22:15] are nonzero, output magnitude = 0x7FFF and `overflow = 1`.
- **Divide by zero:** output magnitude = 0x7FFF, `div_by_zero = 1`, sign computed as normal.
- **Zero result:** a zero magnitude forces sign = 0 (no negative zero).
- **Start while busy:** `start` during CALC or DONE is ignored; operands are not recaptured.
- **Input stability:** inputs may change freely after the accept cycle.

## Timing
- **Reset values:** state IDLE, `busy = 0`, `done = 0`, `quotient = 0x0000`, `overflow = 0`, `div_by_zero = 0`.
- **Normal latency:** `start` is sampled at edge N. `busy` is high from edge N through edge N+23. `done` is high for the cycle after edge N+24, with `quotient` updated at that same edge.
- **Divide-by-zero latency:** `done` pulses after edge N+1; `busy` is high only between edges N and N+1.
- **Back-to-back:** a new `start` may be accepted in the IDLE cycle immediately following `done`. Minimum issue interval is 25 cycles (2 cycles for divide-by-zero).
- **Reset mid-operation:** asserting `n_rst` low immediately returns all outputs to their reset values; the in-flight operation is discarded and no `done` is produced.

## Structure
- **Shared package `fixed_point_pkg`:** `WIDTH`, `FRAC`, `MAG_MAX = 15'h7FFF`, and the `div_state_t` enum (IDLE, CALC, DONE). The `fixed_point_math` multiplier also imports this package.
- **Sub-module `fp_div_step`:** combinational single restoring step. Inputs: remainder, divisor magnitude, incoming bit. Outputs: next remainder and quotient bit.
- **Top level:** holds the FSM, iteration counter (5 bits, counts 22 down to 0), shift registers and result formatting.

## Test plan
- 0x0040 / 0x0080 (0.25/0.5) → `quotient = 0x0080`, `done` 24 edges after `start`, flags 0.
- 0x0900 / 0x0300 (9/3) → 0x0300; 0x8900 / 0x0300 → 0x8300; 0x8900 / 0x8300 → 0x0300.
- 0x0100 / 0x0300 (1/3) → 0x0055 (truncated); 0x0000 / 0x8300 → 0x0000 (sign cleared).
- 0x7F00 / 0x0001 → 0x7FFF with `overflow = 1`; 0x8100 / 0x0000 → 0xFFFF with `div_by_zero = 1`, `done` one edge after accept.
- `start` re-pulsed with new operands during CALC → ignored, original result returned. Second `start` in the IDLE cycle after `done` → accepted.
- `n_rst` low at iteration 10 → outputs 0x0000/0/0 immediately, no `done`. A fresh divide afterwards completes correctly.

Source files
------------

// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_pkg
// Purpose  : Shared definitions for the Q8.8 sign-magnitude arithmetic blocks
//            (fixed_point_math multiplier, fixed_point_divide divider).
// Contents : word/fraction widths, saturation magnitude, divider FSM states,
//            and a helper that builds a sign-magnitude word.
// Revision : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  // Largest representable magnitude; used for every saturating result.
  localparam logic [WIDTH-2:0] MAG_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Assemble a sign-magnitude word. A zero magnitude always yields +0 so the
  // datapath never emits a negative zero.
  function automatic logic [WIDTH-1:0] sm_pack(input logic sgn, input logic [WIDTH-2:0] mag);
    return {sgn & (mag != '0), mag};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_step
// Purpose  : One combinational restoring-division step. Shifts the partial
//            remainder left, brings in the next numerator bit and subtracts
//            the divisor magnitude when it fits.
// Ports    : rem       in  WIDTH    current partial remainder
//            den_mag   in  WIDTH-1  divisor magnitude
//            bit_in    in  1        next numerator bit (MSB first)
//            rem_next  out WIDTH    partial remainder after this step
//            q_bit     out 1        quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_step
  import fixed_point_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic [STEP_W-1:0] rem,
  input  logic [STEP_W-2:0] den_mag,
  input  logic              bit_in,
  output logic [STEP_W-1:0] rem_next,
  output logic              q_bit
);

  logic [STEP_W-1:0] shifted;
  logic [STEP_W-1:0] den_ext;
  logic              fits;

  assign shifted = {rem[STEP_W-2:0], bit_in};
  assign den_ext = {1'b0, den_mag};

  // The remainder stays below the divisor, so its top bit is always clear.
  // Should it ever be set, the true shifted value exceeds any divisor and a
  // subtraction is still the right answer.
  assign fits     = rem[STEP_W-1] | (shifted >= den_ext);
  assign q_bit    = fits;
  assign rem_next = fits ? (shifted - den_ext) : shifted;

endmodule
`default_nettype wire

// File: rtl/fixed_point_divide.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_divide
// Purpose  : Sequential Q8.8 sign-magnitude divider, one quotient bit per
//            clock using a restoring shift-subtract loop. Start/done handshake.
// Ports    : clk          in  1      rising-edge clock
//            n_rst        in  1      asynchronous active-low reset
//            start        in  1      request, sampled only while idle
//            dividend     in  WIDTH  numerator, captured on accept
//            divisor      in  WIDTH  denominator, captured on accept
//            busy         out 1      operation in flight
//            done         out 1      one-cycle pulse, result valid from here
//            quotient     out WIDTH  result, held until the next result
//            overflow     out 1      result saturated
//            div_by_zero  out 1      divisor magnitude was zero
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_divide
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int MAG_W = WIDTH - 1;
  localparam int NUM_W = MAG_W + FRAC;
  localparam int CNT_W = $clog2(NUM_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W - 1);
  localparam logic [MAG_W-1:0] SAT_MAG  = {MAG_W{1'b1}};

  div_state_t state;
  div_state_t state_next;

  logic             accept;
  logic             zero_div;

  logic [MAG_W-1:0] den_mag;
  logic [NUM_W-1:0] num_sr;
  logic [NUM_W-1:0] quo_raw;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             sign;
  logic             dbz_pend;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  logic             res_ovf;
  logic [MAG_W-1:0] res_mag;

  assign zero_div = (divisor[MAG_W-1:0] == '0);
  assign accept   = (state == IDLE) && start;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state != IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  fp_div_step #(
    .STEP_W (WIDTH)
  ) u_step (
    .rem      (rem),
    .den_mag  (den_mag),
    .bit_in   (num_sr[NUM_W-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Any raw quotient bit above the output magnitude means the result does not
  // fit. A divide-by-zero leaves the raw quotient cleared, so it never also
  // reports overflow.
  assign res_ovf = |quo_raw[NUM_W-1:MAG_W];
  assign res_mag = (dbz_pend || res_ovf) ? SAT_MAG : quo_raw[MAG_W-1:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      den_mag     <= '0;
      num_sr      <= '0;
      quo_raw     <= '0;
      rem         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      dbz_pend    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            den_mag     <= divisor[MAG_W-1:0];
            num_sr      <= {dividend[MAG_W-1:0], {FRAC{1'b0}}};
            quo_raw     <= '0;
            rem         <= '0;
            cnt         <= CNT_LAST;
            sign        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dbz_pend    <= zero_div;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          rem     <= rem_next;
          num_sr  <= {num_sr[NUM_W-2:0], 1'b0};
          quo_raw <= {quo_raw[NUM_W-2:0], q_bit};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // The result is formatted from the finished raw quotient and
          // published together with the done pulse.
          quotient    <= sm_pack(sign, res_mag);
          overflow    <= res_ovf & ~dbz_pend;
          div_by_zero <= dbz_pend;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_divide.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_point_divide
// Purpose  : Self-checking bench for fixed_point_divide. Expected results are
//            queued when a request is accepted and compared on each done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_point_divide;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  fixed_point_divide #(
    .WIDTH (16),
    .FRAC  (8)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: integer division of the scaled magnitudes.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int unsigned am;
    int unsigned bm;
    int unsigned raw;
    logic [14:0] mag;
    am    = int'(a[14:0]);
    bm    = int'(b[14:0]);
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.cyc = 0;
    if (bm == 0) begin
      mag   = 15'h7FFF;
      e.dbz = 1'b1;
    end else begin
      raw = (am << 8) / bm;
      if (raw > 32'h7FFF) begin
        mag   = 15'h7FFF;
        e.ovf = 1'b1;
      end else begin
        mag = raw[14:0];
      end
    end
    e.q = {(a[15] ^ b[15]) && (mag != 15'd0), mag};
    return e;
  endfunction

  // Present a request; it is accepted on the next rising edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic o, input logic z,
                       input bit push);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (push) begin
      e.q   = q;
      e.ovf = o;
      e.dbz = z;
      e.cyc = cyc + (z ? 1 : 24);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] q, input logic o, input logic z);
    issue(a, b, q, o, z, 1'b1);
    wait_done();
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    32'(quotient),    32'(e.q));
        check("overflow",    32'(overflow),    32'(e.ovf));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("done_cycle",  32'(cyc),         32'(e.cyc));
        check("busy_at_done", 32'(busy),       32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t m;
    logic [15:0] ra;
    logic [15:0] rb;

    repeat (3) @(negedge clk);
    check("rst_quotient", 32'(quotient),    32'h0);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_done",     32'(done),        32'd0);
    check("rst_overflow", 32'(overflow),    32'd0);
    check("rst_dbz",      32'(div_by_zero), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors
    run(16'h0040, 16'h0080, 16'h0080, 1'b0, 1'b0);
    run(16'h0900, 16'h0300, 16'h0300, 1'b0, 1'b0);
    run(16'h8900, 16'h0300, 16'h8300, 1'b0, 1'b0);
    run(16'h8900, 16'h8300, 16'h0300, 1'b0, 1'b0);
    run(16'h0000, 16'h8300, 16'h0000, 1'b0, 1'b0);
    run(16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    run(16'h8100, 16'h0000, 16'hFFFF, 1'b0, 1'b1);

    // start re-pulsed mid-calculation must be ignored
    issue(16'h0900, 16'h0300, 16'h0300, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    dividend = 16'h0100;
    divisor  = 16'h0000;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Back-to-back: second start in the idle cycle carrying done
    issue(16'h0040, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(16'h8100, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    wait_done();
    issue(16'h8900, 16'h0300, 16'h8300, 1'b0, 1'b0, 1'b1);
    wait_done();

    // Reset mid-operation (quotient currently holds 0x8300)
    issue(16'h0900, 16'h0300, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst_quotient", 32'(quotient),    32'h0);
    check("midrst_overflow", 32'(overflow),    32'd0);
    check("midrst_dbz",      32'(div_by_zero), 32'd0);
    check("midrst_busy",     32'(busy),        32'd0);
    check("midrst_done",     32'(done),        32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    run(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);
    run(16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Random operands against the arithmetic reference
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 13);
      rb[15] = 1'($urandom);
      m = model(ra, rb);
      run(ra, rb, m.q, m.ovf, m.dbz);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
